// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle for the data memory stage.
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake (master drives)
//   mem_out   : last completed load byte (slave drives)
//   resp_valid: one-cycle completion pulse (slave drives)
//   busy      : access in flight, used as pipeline stall (slave drives)
interface dmem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] mem_out;
  logic              resp_valid;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, mem_out, resp_valid, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, mem_out, resp_valid, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory stage of the 8-bit datapath.
// One load or store per accepted request, completing LATENCY cycles after
// the accept cycle. Storage is a 2^ADDR_W x DATA_W array inside the block
// (not cleared by reset).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_ctrl_if.slave (request handshake, mem_out, resp_valid, busy)
//   load_count, store_count : accepted-request counters, saturating at 0xFFFF
//                             (present only when DMEM_STATS_EN is defined)
// Optional feature macro: DMEM_STATS_EN
module dmem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] load_count,
  output logic [15:0] store_count
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_ctrl: LATENCY must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] mem_out_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              accept;
  logic              fin;
  logic              fin_write;
  logic [ADDR_W-1:0] fin_addr;
  logic [DATA_W-1:0] fin_wdata;

  assign accept = bus.req_valid && bus.req_ready;

  // Completion happens on the edge entering RESP. With LATENCY == 1 that is
  // the accept edge itself, so the live request fields are used instead of
  // the latched copy. Gating with rst_n keeps an access held during reset
  // from touching the array.
  assign fin = rst_n && ((state == WAIT && cnt == 4'd1) ||
                         (LATENCY == 1 && accept));
  assign fin_write = (LATENCY == 1) ? bus.req_write : acc_write;
  assign fin_addr  = (LATENCY == 1) ? bus.req_addr  : acc_addr;
  assign fin_wdata = (LATENCY == 1) ? bus.req_wdata : acc_wdata;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bus.req_ready  = 1'b1;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE, RESP: begin
        bus.resp_valid = (state == RESP);
        if (accept) begin
          cnt_nxt   = CNT_INIT;
          state_nxt = (LATENCY > 1) ? WAIT : RESP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        bus.req_ready = 1'b0;
        bus.busy      = 1'b1;
        cnt_nxt       = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_write <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      mem_out_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        acc_write <= bus.req_write;
        acc_addr  <= bus.req_addr;
        acc_wdata <= bus.req_wdata;
      end
      if (fin && !fin_write) mem_out_q <= mem[fin_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (fin && fin_write) mem[fin_addr] <= fin_wdata;
  end

  assign bus.mem_out = mem_out_q;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (accept) begin
      if (bus.req_write) begin
        if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      end else begin
        if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: two instances (LATENCY=2 as d=0, LATENCY=1 as d=1) driven by
// directed steps; accepted requests are queued with their due cycle and
// checked against a memory model when resp_valid appears.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) b0();
  dmem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) b1();

`ifdef DMEM_STATS_EN
  logic [15:0] lc0, sc0, lc1, sc1;
`endif

  dmem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
`ifdef DMEM_STATS_EN
    , .load_count(lc0), .store_count(sc0)
`endif
  );

  dmem_ctrl #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef DMEM_STATS_EN
    , .load_count(lc1), .store_count(sc1)
`endif
  );

  typedef struct {
    int         d;
    int         due;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ent_t;

  ent_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         lat[2] = '{2, 1};
  logic [7:0] model[2][256];
  logic [7:0] last_ld[2] = '{8'h00, 8'h00};
  int         exp_ld[2] = '{0, 0};
  int         exp_st[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending(input int d);
    int n = 0;
    foreach (sb[i]) if (sb[i].d == d) n++;
    return n;
  endfunction

  // Scoreboard step for one instance, sampled on the falling edge.
  task automatic mon(input int d, input logic v, input logic rdy, input logic wr,
                     input logic [7:0] a, input logic [7:0] wd, input logic rv,
                     input logic bz, input logic [7:0] mo);
    int   idx;
    ent_t e;
    if (!rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
      last_ld[d] = 8'h00;
      exp_ld[d]  = 0;
      exp_st[d]  = 0;
      return;
    end
    if (rv) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) if (sb[i].d == d) begin idx = i; break; end
      check($sformatf("resp_pending_d%0d", d), (idx >= 0), 1);
      if (idx >= 0) begin
        e = sb[idx];
        sb.delete(idx);
        check($sformatf("resp_cycle_d%0d", d), cyc, e.due);
        if (e.wr) model[d][e.addr] = e.wdata;
        else      last_ld[d] = model[d][e.addr];
        check($sformatf("mem_out_d%0d", d), mo, last_ld[d]);
      end
    end
    if (d == 1) check("lat1_busy", bz, 0);
    if (v && rdy) begin
      e.d = d; e.due = cyc + lat[d]; e.wr = wr; e.addr = a; e.wdata = wd;
      sb.push_back(e);
      if (wr) begin if (exp_st[d] < 65535) exp_st[d]++; end
      else    begin if (exp_ld[d] < 65535) exp_ld[d]++; end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.req_valid, b0.req_ready, b0.req_write, b0.req_addr, b0.req_wdata,
        b0.resp_valid, b0.busy, b0.mem_out);
    mon(1, b1.req_valid, b1.req_ready, b1.req_write, b1.req_addr, b1.req_wdata,
        b1.resp_valid, b1.busy, b1.mem_out);
  end

  // Present a request, hold it until accepted; returns #1 after the accept edge.
  task automatic req(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    logic ok = 1'b0;
    if (d == 0) begin b0.req_write = wr; b0.req_addr = a; b0.req_wdata = wd; b0.req_valid = 1'b1; end
    else        begin b1.req_write = wr; b1.req_addr = a; b1.req_wdata = wd; b1.req_valid = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((d == 0) ? b0.req_ready : b1.req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (d == 0) b0.req_valid = 1'b0; else b1.req_valid = 1'b0;
    check($sformatf("accept_d%0d", d), ok, 1);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 30; i++) begin
      if (pending(d) == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check($sformatf("drain_d%0d", d), pending(d), 0);
  endtask

  initial begin
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    #2 rst_n = 1'b0;

    // 1: reset with a request presented
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 8'h55; b0.req_wdata = 8'hEE;
    b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_addr = 8'h55; b1.req_wdata = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", b0.req_ready, 1);
    check("rst_resp0",  b0.resp_valid, 0);
    check("rst_busy0",  b0.busy, 0);
    check("rst_mem0",   b0.mem_out, 8'h00);
    check("rst_ready1", b1.req_ready, 1);
    check("rst_resp1",  b1.resp_valid, 0);
    check("rst_mem1",   b1.mem_out, 8'h00);
    b0.req_valid = 1'b0; b1.req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy0", b0.busy, 0);
    check("post_rst_resp1", b1.resp_valid, 0);

    // 2: LATENCY=2 store then load
    req(0, 1'b1, 8'h10, 8'hA5);
    check("t2_busy_c1", b0.busy, 1);
    check("t2_resp_c1", b0.resp_valid, 0);
    @(posedge clk); #1;
    check("t2_resp_c2", b0.resp_valid, 1);
    check("t2_mem_unch", b0.mem_out, 8'h00);
    drain(0);
    req(0, 1'b0, 8'h10, 8'h00);
    drain(0);
    check("t2_load", b0.mem_out, 8'hA5);

    // 3: back-to-back loads, second held during WAIT
    req(0, 1'b1, 8'hFF, 8'h5A);
    drain(0);
    req(0, 1'b0, 8'h10, 8'h00);
    req(0, 1'b0, 8'hFF, 8'h00);
    check("t3_busy_after_b2b", b0.busy, 1);
    drain(0);
    check("t3_load2", b0.mem_out, 8'h5A);

    // 4: LATENCY=1 store/load of zero at address zero, plus a back-to-back pair
    req(1, 1'b1, 8'h00, 8'h00);
    check("t4_resp_st", b1.resp_valid, 1);
    check("t4_busy_st", b1.busy, 0);
    drain(1);
    req(1, 1'b0, 8'h00, 8'h00);
    check("t4_resp_ld", b1.resp_valid, 1);
    drain(1);
    check("t4_load", b1.mem_out, 8'h00);
    req(1, 1'b1, 8'h33, 8'h77);
    req(1, 1'b0, 8'h33, 8'h00);
    drain(1);
    check("t4_b2b_load", b1.mem_out, 8'h77);

    // 5: reset during WAIT aborts the pending store
    req(0, 1'b1, 8'h20, 8'h11);
    drain(0);
    req(0, 1'b1, 8'h20, 8'h3C);
    check("t5_in_wait", b0.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_ready", b0.req_ready, 1);
    check("t5_busy",  b0.busy, 0);
    check("t5_resp",  b0.resp_valid, 0);
    check("t5_mem",   b0.mem_out, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    req(0, 1'b0, 8'h20, 8'h00);
    drain(0);
    check("t5_load_old", b0.mem_out, 8'h11);

`ifdef DMEM_STATS_EN
    // 6: counters, then store_count saturation on the single-cycle instance
    req(0, 1'b1, 8'h01, 8'h01);
    req(0, 1'b0, 8'h01, 8'h00);
    req(0, 1'b0, 8'h20, 8'h00);
    drain(0);
    check("t6_lc0", lc0, exp_ld[0]);
    check("t6_sc0", sc0, exp_st[0]);
    check("t6_lc1", lc1, exp_ld[1]);
    check("t6_sc1", sc1, exp_st[1]);
    for (int i = 0; i < 65540; i++) req(1, 1'b1, 8'(i), 8'(i + 1));
    drain(1);
    check("t6_sat_sc1", sc1, 16'hFFFF);
    check("t6_lc1_hold", lc1, exp_ld[1]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
